// File: rtl/interp_ch_sched.sv
// -----------------------------------------------------------------------------
// interp_ch_sched
//   Shares one factor-INTERP_L interpolator datapath between NUM_CH channels.
//   A round-robin arbiter accepts one sample from a requesting channel.
//   The block then sequences INTERP_L output beats for that sample.
//   Beat 0 carries the sample; the remaining beats are zero-stuffed.
//
// Parameters
//   NUM_CH    number of requesting channels (>=1)
//   INTERP_L  interpolation factor, output beats per input sample (>=2)
//
// Ports
//   clk            rising-edge clock
//   arst           asynchronous reset, active-high; forces every output to 0
//   src_valid_in   per-channel sample valid
//   src_ready_out  per-channel accept, one-hot or zero (Mealy on src_valid_in)
//   dst_valid_out  output beat valid to the downstream datapath
//   dst_ready_in   downstream ready
//   en_out         datapath advance, dst_valid_out & dst_ready_in
//   dm_out         1 = sample beat (phase 0), 0 = zero-stuffed beat
//   ld_out         load the accepted sample into the channel input register
//   ch_sel_out     channel owning the datapath (0 while idle)
//   phase_out      current output phase (0 while idle)
//   busy_out       high while beats are being emitted
//
// Configuration macro
//   INTERP_SCHED_BTB_EN  back-to-back mode. The arbiter also runs on the final
//                        beat handshake, so the next sample is accepted in the
//                        same cycle and the idle bubble between samples is removed.
// -----------------------------------------------------------------------------
module interp_ch_sched #(
  parameter int NUM_CH   = 4,
  parameter int INTERP_L = 2,
  localparam int CH_W    = (NUM_CH   > 1) ? $clog2(NUM_CH)   : 1,
  localparam int PH_W    = (INTERP_L > 1) ? $clog2(INTERP_L) : 1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [NUM_CH-1:0] src_valid_in,
  output logic [NUM_CH-1:0] src_ready_out,
  output logic              dst_valid_out,
  input  logic              dst_ready_in,
  output logic              en_out,
  output logic              dm_out,
  output logic              ld_out,
  output logic [CH_W-1:0]   ch_sel_out,
  output logic [PH_W-1:0]   phase_out,
  output logic              busy_out
);

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(INTERP_L - 1);

  state_t            r_state,  w_state_nxt;
  logic [PH_W-1:0]   r_phase,  w_phase_nxt;
  logic [CH_W-1:0]   r_cur_ch, w_cur_ch_nxt;
  logic [CH_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;

  logic [CH_W-1:0]   w_arb_base;
  logic              w_arb_found;
  logic [CH_W-1:0]   w_arb_idx;
  logic [NUM_CH-1:0] w_arb_onehot;

  logic [NUM_CH-1:0] w_src_ready;
  logic              w_dst_valid;
  logic              w_dm;
  logic              w_ld;
  logic [CH_W-1:0]   w_ch_sel;
  logic [PH_W-1:0]   w_phase_o;
  logic              w_busy;

  // ---------------------------------------------------------------------------
  // Round-robin search. It starts one past base and wraps, so the channel
  // served last has the lowest priority next time.
  // ---------------------------------------------------------------------------
  function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                            input logic [CH_W-1:0]   base);
    logic            found;
    logic [CH_W-1:0] idx;
    int              c;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (int'(base) + k) % NUM_CH;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = CH_W'(c);
      end
    end
    return {found, idx};
  endfunction

  // While idle, the search starts after rr_ptr.
  // On the back-to-back path, it starts after the channel that just finished.
  assign w_arb_base                = (r_state == ST_IDLE) ? r_rr_ptr : r_cur_ch;
  assign {w_arb_found, w_arb_idx}  = rr_pick(src_valid_in, w_arb_base);
  assign w_arb_onehot              = NUM_CH'(1) << w_arb_idx;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state  <= ST_IDLE;
      r_phase  <= '0;
      r_cur_ch <= '0;
      r_rr_ptr <= CH_W'(NUM_CH - 1);
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_cur_ch <= w_cur_ch_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_cur_ch_nxt = r_cur_ch;
    w_rr_ptr_nxt = r_rr_ptr;
    w_src_ready  = '0;
    w_dst_valid  = 1'b0;
    w_dm         = 1'b0;
    w_ld         = 1'b0;
    w_ch_sel     = '0;
    w_phase_o    = '0;
    w_busy       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_arb_found) begin
          w_src_ready  = w_arb_onehot;
          w_ld         = 1'b1;
          w_cur_ch_nxt = w_arb_idx;
          w_phase_nxt  = '0;
          w_state_nxt  = ST_EMIT;
        end
      end

      ST_EMIT: begin
        w_dst_valid = 1'b1;
        w_busy      = 1'b1;
        w_dm        = (r_phase == '0);
        w_ch_sel    = r_cur_ch;
        w_phase_o   = r_phase;
        // With downstream stalled, everything holds.
        if (dst_ready_in) begin
          if (r_phase != LAST_PH) begin
            w_phase_nxt = r_phase + PH_W'(1);
          end else begin
            w_rr_ptr_nxt = r_cur_ch;
            w_phase_nxt  = '0;
            w_state_nxt  = ST_IDLE;
`ifdef INTERP_SCHED_BTB_EN
            // Accept the next sample on the final beat and stay in EMIT.
            // This keeps dst_valid_out high with no gap between samples.
            if (w_arb_found) begin
              w_src_ready  = w_arb_onehot;
              w_ld         = 1'b1;
              w_cur_ch_nxt = w_arb_idx;
              w_rr_ptr_nxt = w_arb_idx;
              w_state_nxt  = ST_EMIT;
            end
`endif
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The idle-state outputs are Mealy on src_valid_in.
  // They are gated so the block is fully quiet while reset is held.
  assign src_ready_out = arst ? '0   : w_src_ready;
  assign dst_valid_out = arst ? 1'b0 : w_dst_valid;
  assign dm_out        = arst ? 1'b0 : w_dm;
  assign ld_out        = arst ? 1'b0 : w_ld;
  assign ch_sel_out    = arst ? '0   : w_ch_sel;
  assign phase_out     = arst ? '0   : w_phase_o;
  assign busy_out      = arst ? 1'b0 : w_busy;
  assign en_out        = dst_valid_out & dst_ready_in;

endmodule

// File: tb/tb_interp_ch_sched.sv
module tb_interp_ch_sched;
  localparam int NUM_CH   = 4;
  localparam int INTERP_L = 4;
  localparam int CH_W     = 2;
  localparam int PH_W     = 2;

  logic              clk = 1'b0;
  logic              arst;
  logic [NUM_CH-1:0] src_valid_in;
  logic [NUM_CH-1:0] src_ready_out;
  logic              dst_valid_out;
  logic              dst_ready_in;
  logic              en_out, dm_out, ld_out, busy_out;
  logic [CH_W-1:0]   ch_sel_out;
  logic [PH_W-1:0]   phase_out;

  int n_checks = 0;
  int n_fail   = 0;

  interp_ch_sched #(.NUM_CH(NUM_CH), .INTERP_L(INTERP_L)) dut (
    .clk(clk), .arst(arst), .src_valid_in(src_valid_in), .src_ready_out(src_ready_out),
    .dst_valid_out(dst_valid_out), .dst_ready_in(dst_ready_in), .en_out(en_out),
    .dm_out(dm_out), .ld_out(ld_out), .ch_sel_out(ch_sel_out), .phase_out(phase_out),
    .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the sample in flight, its beat count, and the last
  // channel served. Expected outputs are derived from these each cycle.
  // ---------------------------------------------------------------------------
  int m_busy = 0, m_ch = 0, m_ph = 0, m_last = NUM_CH - 1;
  int m_grant = -1;

  function automatic int pick(input logic [NUM_CH-1:0] req, input int after);
    for (int k = 1; k <= NUM_CH; k++)
      if (req[(after + k) % NUM_CH]) return (after + k) % NUM_CH;
    return -1;
  endfunction

  logic [NUM_CH-1:0] e_rdy;
  logic e_ld, e_dv, e_dm, e_bz, e_en;
  int   e_ch, e_ph, g;

  always @(negedge clk) begin
    e_rdy = '0; e_ld = 0; e_dv = 0; e_dm = 0; e_bz = 0; e_en = 0; e_ch = 0; e_ph = 0; g = -1;
    if (arst) begin
      m_busy = 0; m_ch = 0; m_ph = 0; m_last = NUM_CH - 1;
    end else if (m_busy == 0) begin
      g = pick(src_valid_in, m_last);
      if (g >= 0) begin
        e_rdy[g] = 1'b1; e_ld = 1; m_busy = 1; m_ch = g; m_ph = 0;
      end
    end else begin
      e_dv = 1; e_bz = 1; e_dm = (m_ph == 0); e_ch = m_ch; e_ph = m_ph; e_en = dst_ready_in;
      if (dst_ready_in) begin
        if (m_ph < INTERP_L - 1) m_ph++;
        else begin
          m_last = m_ch; m_busy = 0;
`ifdef INTERP_SCHED_BTB_EN
          g = pick(src_valid_in, m_ch);
          if (g >= 0) begin
            e_rdy[g] = 1'b1; e_ld = 1; m_busy = 1; m_ch = g; m_ph = 0; m_last = g;
          end
`endif
        end
      end
    end
    m_grant = g;
    chk("m_src_ready", 32'(src_ready_out), 32'(e_rdy));
    chk("m_ld",        32'(ld_out),        32'(e_ld));
    chk("m_dst_valid", 32'(dst_valid_out), 32'(e_dv));
    chk("m_dm",        32'(dm_out),        32'(e_dm));
    chk("m_busy",      32'(busy_out),      32'(e_bz));
    chk("m_en",        32'(en_out),        32'(e_en));
    chk("m_ch_sel",    32'(ch_sel_out),    32'(e_ch));
    chk("m_phase",     32'(phase_out),     32'(e_ph));
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations, then random traffic
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_src_ready"}, 32'(src_ready_out), 0);
    chk({tag, "_dst_valid"}, 32'(dst_valid_out), 0);
    chk({tag, "_en"},        32'(en_out), 0);
    chk({tag, "_ld"},        32'(ld_out), 0);
    chk({tag, "_dm"},        32'(dm_out), 0);
    chk({tag, "_busy"},      32'(busy_out), 0);
    chk({tag, "_ch_sel"},    32'(ch_sel_out), 0);
    chk({tag, "_phase"},     32'(phase_out), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_out && n < 40) begin step(); #2; n++; end
    chk("wait_idle_timeout", 32'(busy_out), 0);
  endtask

  task automatic chk_beat(input string tag, input int ch, input int ph, input logic en);
    chk({tag, "_dst_valid"}, 32'(dst_valid_out), 1);
    chk({tag, "_dm"},        32'(dm_out), 32'(ph == 0));
    chk({tag, "_phase"},     32'(phase_out), 32'(ph));
    chk({tag, "_ch_sel"},    32'(ch_sel_out), 32'(ch));
    chk({tag, "_en"},        32'(en_out), 32'(en));
  endtask

  int             grants[$];
  int             first_g;
  int             exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic [NUM_CH-1:0] pend;
  int             window;

  initial begin
    arst = 1'b0; src_valid_in = '1; dst_ready_in = 1'b0;
    #1 arst = 1'b1;

    // Reset holds every output at 0 even with all channels requesting.
    for (int i = 0; i < 3; i++) begin step(); #2; chk_zero("t1_rst"); end
    step(); arst = 1'b0; #2;
    chk("t1_first_grant", 32'(src_ready_out), 32'h1);
    step(); src_valid_in = '0; dst_ready_in = 1'b1; #2;
    wait_idle();

    // A lone ch2 request gives one grant, four beats, then an idle bubble.
    step(); src_valid_in = 4'b0100; #2;
    chk("t2_grant", 32'(src_ready_out), 32'h4);
    chk("t2_ld", 32'(ld_out), 1);
    chk("t2_idle_dv", 32'(dst_valid_out), 0);
    for (int p = 0; p < INTERP_L; p++) begin
      step(); src_valid_in = '0; #2;
      chk_beat("t2_beat", 2, p, 1'b1);
    end
    step(); #2;
    chk("t2_bubble_dv", 32'(dst_valid_out), 0);
    chk("t2_bubble_busy", 32'(busy_out), 0);

    // A stall at phase 1 holds all outputs and resumes at phase 1.
    step(); src_valid_in = 4'b0001; #2;
    chk("t3_grant", 32'(src_ready_out), 32'h1);
    step(); src_valid_in = '0; #2;
    chk_beat("t3_ph0", 0, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(); dst_ready_in = 1'b0; #2;
      chk_beat("t3_stall", 0, 1, 1'b0);
    end
    step(); dst_ready_in = 1'b1; #2; chk_beat("t3_resume", 0, 1, 1'b1);
    step(); #2; chk_beat("t3_ph2", 0, 2, 1'b1);
    step(); #2; chk_beat("t3_ph3", 0, 3, 1'b1);
    step(); #2; chk("t3_idle_dv", 32'(dst_valid_out), 0);

    // All four channels request continuously, so grants rotate from ch0.
`ifdef INTERP_SCHED_BTB_EN
    window = 8 * INTERP_L;
`else
    window = 8 * (INTERP_L + 1);
`endif
    step(); arst = 1'b1;
    step(); arst = 1'b0; src_valid_in = '1; dst_ready_in = 1'b1;
    first_g = -1;
    for (int c = 0; c < window; c++) begin
      if (c > 0) step();
      #2;
      for (int k = 0; k < NUM_CH; k++)
        if (src_ready_out[k]) begin
          grants.push_back(k);
          if (first_g < 0) first_g = c;
        end
`ifdef INTERP_SCHED_BTB_EN
      if (first_g >= 0 && c > first_g) chk("t5_dv_continuous", 32'(dst_valid_out), 1);
      if (|src_ready_out && c > first_g) chk("t5_grant_on_ph3", 32'(phase_out), 3);
`endif
    end
    chk("t4_grant_count", 32'(grants.size()), 8);
    for (int i = 0; i < 8 && i < grants.size(); i++)
      chk("t4_grant_order", 32'(grants[i]), 32'(exp_order[i]));
    step(); src_valid_in = '0; #2;
    wait_idle();

    // Reset during ch1 phase 2 ends the sample; arbitration restarts from ch0.
    step(); src_valid_in = 4'b0010; #2;
    chk("t6_grant", 32'(src_ready_out), 32'h2);
    step(); src_valid_in = '0; #2; chk_beat("t6_ph0", 1, 0, 1'b1);
    step(); #2; chk_beat("t6_ph1", 1, 1, 1'b1);
    step(); #2; chk_beat("t6_ph2", 1, 2, 1'b1);
    #1 arst = 1'b1; #1;
    chk("t6_rst_dv", 32'(dst_valid_out), 0);
    chk("t6_rst_en", 32'(en_out), 0);
    step(); src_valid_in = 4'b1010; #2;
    chk("t6_rst_ready", 32'(src_ready_out), 0);
    step(); arst = 1'b0; #2;
    chk("t6_regrant", 32'(src_ready_out), 32'h2);
    step(); src_valid_in = 4'b1000; #2;
    chk_beat("t6_restart", 1, 0, 1'b1);
    wait_idle();
    chk("t6_ch3_grant", 32'(src_ready_out), 32'h8);
    step(); src_valid_in = '0; #2;
    wait_idle();

    // Random traffic. Sources hold valid until the model grants them.
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (m_grant >= 0) pend[m_grant] = 1'b0;
      for (int k = 0; k < NUM_CH; k++)
        if (!pend[k] && $urandom_range(0, 9) < 3) pend[k] = 1'b1;
      src_valid_in = pend;
      dst_ready_in = ($urandom_range(0, 9) < 7);
      arst = ($urandom_range(0, 399) == 0);
    end
    step(); arst = 1'b0; src_valid_in = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
